rd_port_arbiter: RTL and testbench



---
 rtl/rd_port_arbiter_if.sv | 26 ++
 rtl/rd_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rd_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_port_arbiter_if.sv
// One AXI-style read channel (AR + R) between a requester and a responder.
// master: the side that issues addresses and accepts beats.
// slave:  the side that accepts addresses and returns beats.
interface rd_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arready;
  logic              rvalid;
  logic              rlast;
  logic [DATA_W-1:0] rdata;
  logic              rready;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rlast, rdata
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rlast, rdata
  );
endinterface

// File: rtl/rd_port_arbiter.sv
// Purpose: shares one read channel between ifetch (m0) and load unit (m1), one whole burst per grant.
// Latency: request seen in IDLE -> s.arvalid next cycle; R beats routed combinationally; one IDLE bubble between bursts.
// Backpressure: losers and late requests see arready=0 until IDLE; s.arready/rready pass through from the winner.
// Build option RD_ARB_RR_EN: round-robin on ties; otherwise master 1 wins ties.
module rd_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  rd_port_arbiter_if.slave    m0,
  rd_port_arbiter_if.slave    m1,
  rd_port_arbiter_if.master   s,
  output logic                grant,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              grant_q;
  logic              busy_q;
  logic              len_err_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;

  logic              any_req;
  logic              win;
  logic              sel_rready;
  logic              ar_hs;
  logic              r_hs;
  logic              len_bad;
  logic [ADDR_W-1:0] sel_araddr;
  logic [DATA_W-1:0] rdata_bcast;

`ifdef RD_ARB_RR_EN
  logic              last_q;
`endif

  // Winner selection for the IDLE cycle; only consulted when any_req is high.
  always_comb begin
    any_req = m0.arvalid | m1.arvalid;
`ifdef RD_ARB_RR_EN
    if (m0.arvalid && m1.arvalid) begin
      win = ~last_q;
    end else begin
      win = m1.arvalid;
    end
`else
    win = m1.arvalid;
`endif
  end

  // Handshake qualifiers and the length check for the beat on the bus this cycle.
  always_comb begin
    sel_rready = grant_q ? m1.rready : m0.rready;
    sel_araddr = grant_q ? m1.araddr : m0.araddr;
    ar_hs      = (state_q == ST_ADDR) && s.arready;
    r_hs       = (state_q == ST_DATA) && s.rvalid && sel_rready;
    // A last beat must land on index len_q, and index len_q must be the last beat.
    len_bad    = s.rlast ? (beat_cnt != len_q) : (beat_cnt == len_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant whole transactions, AR handshake then beats until rlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)         state_d = ST_ADDR;
      ST_ADDR: if (ar_hs)           state_d = ST_DATA;
      ST_DATA: if (r_hs && s.rlast) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Output decode: route AR to the winner in ADDR and R to the winner in DATA, all else quiet.
  always_comb begin
    s.arvalid  = 1'b0;
    s.araddr   = '0;
    s.arlen    = '0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    m0.rlast   = 1'b0;
    m1.rlast   = 1'b0;
    case (state_q)
      ST_ADDR: begin
        s.arvalid = 1'b1;
        s.araddr  = sel_araddr;
        s.arlen   = grant_q ? m1.arlen : m0.arlen;
        if (grant_q) begin
          m1.arready = s.arready;
        end else begin
          m0.arready = s.arready;
        end
      end
      ST_DATA: begin
        s.rready = sel_rready;
        if (grant_q) begin
          m1.rvalid = s.rvalid;
          m1.rlast  = s.rlast;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rlast  = s.rlast;
        end
      end
      default: ;
    endcase
  end

  // Read data is a plain broadcast; rvalid gating alone decides who consumes it.
  assign rdata_bcast = s.rdata;
  assign m0.rdata    = rdata_bcast;
  assign m1.rdata    = rdata_bcast;

  // Per-transaction bookkeeping: grant owner, latched length, beat count, sticky error, busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= 1'b0;
      len_q     <= 8'd0;
      beat_cnt  <= 8'd0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      if ((state_q == ST_IDLE) && any_req) begin
        grant_q  <= win;
        len_q    <= win ? m1.arlen : m0.arlen;
        beat_cnt <= 8'd0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (len_bad) begin
          len_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef RD_ARB_RR_EN
  // Remember the last winner so the next tie goes to the other master; reset favours m0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && any_req) begin
      last_q <= win;
    end
  end
`endif

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Randomized bench for rd_port_arbiter: two requesters and a memory model driven from $urandom,
// outputs compared every cycle against a transaction-level reference of the arbitration rules.
module tb_rd_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic grant, busy, len_err;

  rd_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  rd_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  rd_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  rd_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side
  bit          req_on   [2];
  logic [31:0] req_addr [2];
  logic [7:0]  req_len  [2];
  bit          rdy      [2];

  // Reference: who owns the channel, whether its address was taken, beats delivered so far
  int          own;
  bit          ad_done;
  int          beats;
  logic [31:0] own_addr;
  logic [7:0]  own_len;
  bit          g_exp;
  bit          rr_last;
  bit          err_exp;
  int          txn_done;

  // Memory side
  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t mem_q[$];

  bit hs_ar [2];
  bit hs_s;
  bit acc;
  int err_pct;
  int max_len;

  function automatic logic [31:0] make_data(input logic [31:0] a, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {a[23:0], kk};
  endfunction

  task automatic quiet_inputs();
    m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.rready = 1'b0;
    m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.rready = 1'b0;
    s_if.arready  = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0; s_if.rdata = '0;
  endtask

  task automatic model_reset();
    own = -1; ad_done = 0; beats = 0; own_addr = '0; own_len = '0;
    g_exp = 0; rr_last = 1; err_exp = 0;
    for (int i = 0; i < 2; i++) begin
      req_on[i] = 0; req_addr[i] = '0; req_len[i] = '0; rdy[i] = 0; hs_ar[i] = 0;
    end
    hs_s = 0; acc = 0;
    mem_q.delete();
  endtask

  // Called just after a rising edge: advance requesters and memory by one cycle.
  task automatic drive();
    int  n;
    bit  keep;
    for (int i = 0; i < 2; i++) begin
      if (hs_ar[i]) req_on[i] = 0;
      if (!req_on[i] && $urandom_range(99, 0) < 40) begin
        req_on[i]   = 1;
        req_addr[i] = $urandom;
        req_len[i]  = 8'($urandom_range(max_len, 0));
      end
      rdy[i] = ($urandom_range(3, 0) != 0);
    end
    keep = s_if.rvalid && !acc;
    if (acc) void'(mem_q.pop_front());
    if (hs_s) begin
      n = int'(own_len) + 1;
      if (err_pct > 0 && $urandom_range(99, 0) < err_pct)
        n = (own_len > 0 && $urandom_range(1, 0) == 1) ? int'(own_len) : int'(own_len) + 2;
      for (int k = 0; k < n; k++) mem_q.push_back({make_data(own_addr, k), (k == n - 1)});
    end
    if (!keep) s_if.rvalid = (mem_q.size() > 0) && ($urandom_range(2, 0) != 0);
    if (s_if.rvalid) begin
      s_if.rdata = mem_q[0].d;
      s_if.rlast = mem_q[0].l;
    end else begin
      s_if.rdata = $urandom;
      s_if.rlast = 1'b0;
    end
    s_if.arready  = ($urandom_range(99, 0) < 60);
    m0_if.arvalid = req_on[0]; m0_if.araddr = req_addr[0]; m0_if.arlen = req_len[0]; m0_if.rready = rdy[0];
    m1_if.arvalid = req_on[1]; m1_if.araddr = req_addr[1]; m1_if.arlen = req_len[1]; m1_if.rready = rdy[1];
    hs_ar[0] = 0; hs_ar[1] = 0; hs_s = 0; acc = 0;
  endtask

  // Called on the falling edge: compare outputs, then apply this cycle's events to the reference.
  task automatic check_and_update();
    bit in_addr, in_data, last;
    int w;
    in_addr = (own >= 0) && !ad_done;
    in_data = (own >= 0) && ad_done;
    chk("busy",       busy,           own >= 0);
    chk("grant",      grant,          g_exp);
    chk("len_err",    len_err,        err_exp);
    chk("s_arvalid",  s_if.arvalid,   in_addr);
    if (in_addr) begin
      chk("s_araddr", s_if.araddr, own_addr);
      chk("s_arlen",  s_if.arlen,  own_len);
    end
    chk("m0_arready", m0_if.arready,  in_addr && own == 0 && s_if.arready);
    chk("m1_arready", m1_if.arready,  in_addr && own == 1 && s_if.arready);
    chk("m0_rvalid",  m0_if.rvalid,   in_data && own == 0 && s_if.rvalid);
    chk("m1_rvalid",  m1_if.rvalid,   in_data && own == 1 && s_if.rvalid);
    chk("m0_rlast",   m0_if.rlast,    in_data && own == 0 && s_if.rvalid && s_if.rlast);
    chk("m1_rlast",   m1_if.rlast,    in_data && own == 1 && s_if.rvalid && s_if.rlast);
    chk("s_rready",   s_if.rready,    in_data ? rdy[own] : 1'b0);

    if (own < 0) begin
      if (req_on[0] || req_on[1]) begin
        if (req_on[0] && req_on[1]) begin
`ifdef RD_ARB_RR_EN
          w = rr_last ? 0 : 1;
`else
          w = 1;
`endif
        end else begin
          w = req_on[1] ? 1 : 0;
        end
        own = w; ad_done = 0; beats = 0;
        own_addr = req_addr[w]; own_len = req_len[w];
        g_exp = (w == 1); rr_last = (w == 1);
      end
    end else if (!ad_done) begin
      if (s_if.arready) begin
        ad_done = 1; hs_ar[own] = 1; hs_s = 1;
      end
    end else if (s_if.rvalid && rdy[own]) begin
      acc = 1;
      chk("rdata_owner", (own == 0) ? m0_if.rdata : m1_if.rdata, make_data(own_addr, beats));
      chk("rdata_other", (own == 0) ? m1_if.rdata : m0_if.rdata, make_data(own_addr, beats));
      last = s_if.rlast;
      if (last ? ((beats & 255) != int'(own_len)) : ((beats & 255) == int'(own_len))) err_exp = 1;
      beats++;
      if (last) begin
        own = -1;
        txn_done++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_and_update();
  endtask

  task automatic check_all_quiet(input string ph);
    chk({ph, "_busy"},       busy,          1'b0);
    chk({ph, "_grant"},      grant,         1'b0);
    chk({ph, "_len_err"},    len_err,       1'b0);
    chk({ph, "_s_arvalid"},  s_if.arvalid,  1'b0);
    chk({ph, "_s_araddr"},   s_if.araddr,   32'h0);
    chk({ph, "_s_rready"},   s_if.rready,   1'b0);
    chk({ph, "_m0_arready"}, m0_if.arready, 1'b0);
    chk({ph, "_m1_arready"}, m1_if.arready, 1'b0);
    chk({ph, "_m0_rvalid"},  m0_if.rvalid,  1'b0);
    chk({ph, "_m1_rvalid"},  m1_if.rvalid,  1'b0);
    chk({ph, "_m0_rlast"},   m0_if.rlast,   1'b0);
    chk({ph, "_m1_rlast"},   m1_if.rlast,   1'b0);
  endtask

  initial begin
    bit found;
    txn_done = 0; err_pct = 0; max_len = 7;
    model_reset();
    quiet_inputs();
    #1 rst = 1'b1;
    // Busy-looking inputs while in reset: every gated output must still be 0.
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_quiet("reset");
    quiet_inputs();
    rst = 1'b0;

    // Clean traffic
    repeat (1500) step();

    // Traffic with wrong-length bursts from memory
    err_pct = 25;
    repeat (1000) step();
    chk("len_err_sticky_end", len_err, 1'b1);
    err_pct = 0;

    // Asynchronous reset in the middle of a multi-beat burst
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      step();
      if (own >= 0 && ad_done && beats >= 1 && own_len >= 2) found = 1;
    end
    chk("mid_data_found", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_quiet("async_rst");
    model_reset();
    quiet_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_quiet("rst_held");
    rst = 1'b0;

    // Normal arbitration after reset, no errors expected
    repeat (1000) step();
    chk("txn_count_ok", txn_done > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
